// File: rtl/rv_iopmp_check_arbiter.sv
// Round-robin arbiter/sequencer sharing one IOPMP transaction-check engine among NUM_REQ requesters.
// Optional watchdog (TOUT state, timeout_o port) is enabled by defining RV_IOPMP_ARB_TIMEOUT_EN.
package rv_iopmp_pkg;
  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } access_t;
endpackage

module rv_iopmp_check_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int SID_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_final_addr_i,
  input  logic [NUM_REQ-1:0][$clog2(DATA_WIDTH/8):0] req_num_bytes_i,
  input  logic [NUM_REQ-1:0][SID_WIDTH-1:0]         req_sid_i,
  input  access_t [NUM_REQ-1:0]                     req_access_i,
  output logic [NUM_REQ-1:0]                        rsp_valid_o,
  output logic                                      rsp_allow_o,
  input  logic [NUM_REQ-1:0]                        rsp_ready_i,
  output logic                                      chk_en_o,
  output logic [ADDR_WIDTH-1:0]                     chk_addr_o,
  output logic [ADDR_WIDTH-1:0]                     chk_final_addr_o,
  output logic [$clog2(DATA_WIDTH/8):0]             chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]                      chk_sid_o,
  output access_t                                   chk_access_o,
  input  logic                                      chk_ready_i,
  input  logic                                      chk_valid_i,
  input  logic                                      chk_err_i,
  output logic                                      busy_o
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
  ,
  output logic                                      timeout_o
`endif
);

  localparam int NB_W  = $clog2(DATA_WIDTH/8) + 1;
  localparam int IDX_W = (NUM_REQ > 1 && TIMEOUT_CYCLES > 0) ? $clog2(NUM_REQ) : 1;

`ifdef RV_IOPMP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3, S_TOUT = 3'd4
  } state_t;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d, grant_q, grant_d;
  logic                   allow_q, allow_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, final_q, final_d;
  logic [NB_W-1:0]        nb_q, nb_d;
  logic [SID_WIDTH-1:0]   sid_q, sid_d;
  access_t                acc_q, acc_d;
  logic                   chk_en_q, chk_en_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   rsp_allow_q, rsp_allow_d;
  logic                   busy_q, busy_d;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx, cand;

  // First valid requester at or after the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    allow_d     = allow_q;
    addr_d      = addr_q;
    final_d     = final_q;
    nb_d        = nb_q;
    sid_d       = sid_q;
    acc_d       = acc_q;
    req_ready_o = '0;
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (chk_ready_i && sel_found && !rst_i) begin
          req_ready_o[sel_idx] = 1'b1;
          grant_d = sel_idx;
          addr_d  = req_addr_i[sel_idx];
          final_d = req_final_addr_i[sel_idx];
          nb_d    = req_num_bytes_i[sel_idx];
          sid_d   = req_sid_i[sel_idx];
          acc_d   = req_access_i[sel_idx];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // Deny takes priority when the engine flags both at once.
        if (chk_err_i) begin
          allow_d = 1'b0;
          state_d = S_RESP;
        end else if (chk_valid_i) begin
          allow_d = 1'b1;
          state_d = S_RESP;
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = S_TOUT;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
      S_TOUT: begin
        allow_d = 1'b0;
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready_i[grant_q]) begin
          ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    chk_en_d    = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
    rsp_allow_d = (state_d == S_RESP) && allow_d;
    rsp_valid_d = '0;
    if (state_d == S_RESP) begin
      rsp_valid_d[grant_d] = 1'b1;
    end
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
    timeout_d = (state_d == S_TOUT);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      allow_q     <= 1'b0;
      addr_q      <= '0;
      final_q     <= '0;
      nb_q        <= '0;
      sid_q       <= '0;
      acc_q       <= ACCESS_NONE;
      chk_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_allow_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      allow_q     <= allow_d;
      addr_q      <= addr_d;
      final_q     <= final_d;
      nb_q        <= nb_d;
      sid_q       <= sid_d;
      acc_q       <= acc_d;
      chk_en_q    <= chk_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_allow_q <= rsp_allow_d;
      busy_q      <= busy_d;
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_allow_o      = rsp_allow_q;
  assign chk_en_o         = chk_en_q;
  assign chk_addr_o       = addr_q;
  assign chk_final_addr_o = final_q;
  assign chk_num_bytes_o  = nb_q;
  assign chk_sid_o        = sid_q;
  assign chk_access_o     = acc_q;
  assign busy_o           = busy_q;
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`endif

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Randomized bench for rv_iopmp_check_arbiter: transaction-level reference model feeds
// expectation queues, an independent monitor compares DUT outputs against them.
module tb_rv_iopmp_check_arbiter;
  import rv_iopmp_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int NB = $clog2(DW/8) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_i;
  logic [N-1:0]             req_valid_i, req_ready_o;
  logic [N-1:0][AW-1:0]     req_addr_i, req_final_addr_i;
  logic [N-1:0][NB-1:0]     req_num_bytes_i;
  logic [N-1:0][SW-1:0]     req_sid_i;
  access_t [N-1:0]          req_access_i;
  logic [N-1:0]             rsp_valid_o, rsp_ready_i;
  logic                     rsp_allow_o;
  logic                     chk_en_o;
  logic [AW-1:0]            chk_addr_o, chk_final_addr_o;
  logic [NB-1:0]            chk_num_bytes_o;
  logic [SW-1:0]            chk_sid_o;
  access_t                  chk_access_o;
  logic                     chk_ready_i, chk_valid_i, chk_err_i, busy_o;

  rv_iopmp_check_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_final_addr_i(req_final_addr_i),
    .req_num_bytes_i(req_num_bytes_i), .req_sid_i(req_sid_i), .req_access_i(req_access_i),
    .rsp_valid_o(rsp_valid_o), .rsp_allow_o(rsp_allow_o), .rsp_ready_i(rsp_ready_i),
    .chk_en_o(chk_en_o), .chk_addr_o(chk_addr_o), .chk_final_addr_o(chk_final_addr_o),
    .chk_num_bytes_o(chk_num_bytes_o), .chk_sid_o(chk_sid_o), .chk_access_o(chk_access_o),
    .chk_ready_i(chk_ready_i), .chk_valid_i(chk_valid_i), .chk_err_i(chk_err_i),
    .busy_o(busy_o)
  );

  typedef struct {
    int            idx;
    logic [AW-1:0] a;
    logic [AW-1:0] fa;
    logic [NB-1:0] nb;
    logic [SW-1:0] sid;
    access_t       acc;
  } op_t;

  typedef struct {
    int idx;
    bit allow;
  } rsp_t;

  op_t  op_q[$];
  rsp_t rsp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: pending requests per requester and the transaction phase
  // (0 idle, 1 issue, 2 waiting for verdict, 3 responding).
  bit            pv[N];
  logic [AW-1:0] pa[N], pfa[N];
  logic [NB-1:0] pnb[N];
  logic [SW-1:0] psid[N];
  access_t       pacc[N];
  int            phase = 0, ptr = 0, cur = 0, wcnt = 0;
  logic [N-1:0]  exp_ready, exp_rsp_valid;
  bit            exp_chk_en, exp_busy, exp_zero_ops, last_rst, mon_en;
  bit            applied, rst_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(input bit allow_new, input bit want_rst, input bit eng_off, output bit did_rst);
    int  g, nxt, r, idx;
    bit  v, e;
    @(negedge clk);
    mon_en       = 1'b1;
    did_rst      = 1'b0;
    rst_i        = 1'b0;
    exp_zero_ops = last_rst;
    last_rst     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && allow_new && $urandom_range(0, 3) == 0) begin
        pv[i]   = 1'b1;
        pa[i]   = {$urandom, $urandom};
        pfa[i]  = pa[i] + 64'($urandom_range(0, 63));
        pnb[i]  = NB'($urandom_range(1, 8));
        psid[i] = SW'($urandom);
        pacc[i] = access_t'(2'($urandom_range(1, 3)));
      end else if (pv[i] && allow_new && $urandom_range(0, 29) == 0) begin
        pv[i] = 1'b0;
      end
      req_valid_i[i]      = pv[i];
      req_addr_i[i]       = pa[i];
      req_final_addr_i[i] = pfa[i];
      req_num_bytes_i[i]  = pnb[i];
      req_sid_i[i]        = psid[i];
      req_access_i[i]     = pacc[i];
      rsp_ready_i[i]      = allow_new ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    chk_ready_i = eng_off ? 1'b0 : (allow_new ? ($urandom_range(0, 4) != 0) : 1'b1);
    // Verdict lines carry noise whenever the engine is not expected to answer.
    chk_valid_i = 1'($urandom_range(0, 1));
    chk_err_i   = 1'($urandom_range(0, 1));

    exp_ready     = '0;
    exp_chk_en    = (phase == 1);
    exp_busy      = (phase != 0);
    exp_rsp_valid = '0;
    if (phase == 3) exp_rsp_valid[cur] = 1'b1;
    nxt = phase;
    case (phase)
      0: begin
        g = -1;
        if (chk_ready_i) begin
          for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && pv[idx]) g = idx;
          end
        end
        if (g >= 0) begin
          exp_ready[g] = 1'b1;
          op_q.push_back('{idx: g, a: pa[g], fa: pfa[g], nb: pnb[g], sid: psid[g], acc: pacc[g]});
          pv[g] = 1'b0;
          cur   = g;
          nxt   = 1;
        end
      end
      1: begin
        wcnt = $urandom_range(0, 3);
        nxt  = 2;
      end
      2: begin
        if (want_rst) begin
          rst_i    = 1'b1;
          did_rst  = 1'b1;
          last_rst = 1'b1;
          ptr      = 0;
          nxt      = 0;
        end else if (wcnt == 0) begin
          r = $urandom_range(0, 2);
          v = (r != 1);
          e = (r != 0);
          chk_valid_i = v;
          chk_err_i   = e;
          rsp_q.push_back('{idx: cur, allow: (v && !e)});
          nxt = 3;
        end else begin
          chk_valid_i = 1'b0;
          chk_err_i   = 1'b0;
          wcnt--;
        end
      end
      3: begin
        if (rsp_ready_i[cur]) begin
          ptr = (cur + 1) % N;
          nxt = 0;
        end
      end
      default: nxt = 0;
    endcase
    phase = nxt;
  endtask

  op_t  mon_op;
  rsp_t mon_rsp;
  int   gi;

  // Monitor: samples after inputs settle, away from the active clock edge.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      check("req_ready", 64'(req_ready_o), 64'(exp_ready));
      check("chk_en", 64'(chk_en_o), 64'(exp_chk_en));
      check("busy", 64'(busy_o), 64'(exp_busy));
      check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp_valid));
      if (exp_zero_ops) begin
        check("rst_chk_addr", chk_addr_o, 64'd0);
        check("rst_chk_access", 64'(chk_access_o), 64'(ACCESS_NONE));
        check("rst_rsp_allow", 64'(rsp_allow_o), 64'd0);
      end
      if (chk_en_o) begin
        if (op_q.size() == 0) begin
          check("op_q_level", 64'(op_q.size()), 64'd1);
        end else begin
          mon_op = op_q.pop_front();
          check("chk_addr", chk_addr_o, mon_op.a);
          check("chk_final_addr", chk_final_addr_o, mon_op.fa);
          check("chk_num_bytes", 64'(chk_num_bytes_o), 64'(mon_op.nb));
          check("chk_sid", 64'(chk_sid_o), 64'(mon_op.sid));
          check("chk_access", 64'(chk_access_o), 64'(mon_op.acc));
        end
      end
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_q_level", 64'(rsp_q.size()), 64'd1);
        end else begin
          mon_rsp = rsp_q.pop_front();
          gi = -1;
          for (int i = 0; i < N; i++) begin
            if (rsp_valid_o[i] && rsp_ready_i[i] && gi < 0) gi = i;
          end
          check("rsp_index", 64'(gi), 64'(mon_rsp.idx));
          check("rsp_allow", 64'(rsp_allow_o), 64'(mon_rsp.allow));
        end
      end
    end
  end

  initial begin
    mon_en = 1'b0;
    rst_i = 1'b1;
    req_valid_i = '0; req_addr_i = '0; req_final_addr_i = '0;
    req_num_bytes_i = '0; req_sid_i = '0;
    for (int i = 0; i < N; i++) begin
      req_access_i[i] = ACCESS_NONE;
      pv[i] = 1'b0; pa[i] = '0; pfa[i] = '0; pnb[i] = '0; psid[i] = '0; pacc[i] = ACCESS_NONE;
    end
    rsp_ready_i = '0; chk_ready_i = 1'b0; chk_valid_i = 1'b0; chk_err_i = 1'b0;
    last_rst = 1'b0; rst_pend = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_req_ready", 64'(req_ready_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_rsp_allow", 64'(rsp_allow_o), 64'd0);
    check("reset_chk_en", 64'(chk_en_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_chk_addr", chk_addr_o, 64'd0);
    check("reset_chk_final", chk_final_addr_o, 64'd0);
    check("reset_chk_nb", 64'(chk_num_bytes_o), 64'd0);
    check("reset_chk_sid", 64'(chk_sid_o), 64'd0);
    check("reset_chk_access", 64'(chk_access_o), 64'(ACCESS_NONE));

    for (int c = 0; c < 3000; c++) begin
      if (c == 400 || c == 1300 || c == 2200) rst_pend = 1'b1;
      step(1'b1, rst_pend, (c >= 2600 && c < 2612), applied);
      if (applied) rst_pend = 1'b0;
    end
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b0, 1'b0, applied);
    end
    #3;
    check("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
    check("drain_op_q", 64'(op_q.size()), 64'd0);
    check("drain_busy", 64'(busy_o), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
